i2s_sample_fifo: RTL
====================

Name: i2s_sample_fifo

Overview:
- Sits directly downstream of the I2S receiver master, consuming its 32-bit shifted word and its one-cycle done pulse.
- Tags each word with its channel and keeps the left, right or both channels.
- Formats each kept word as a sign-extended signed sample and buffers it in a first-word-fall-through FIFO.
- Raises a level-based request to the DMA controller, which drains one sample per acknowledge.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- SAMPLE_BITS, 18, valid MSBs taken from the 32-bit I2S word; range 8..32.
- THRESHOLD, 4, fill level at or above which dma_req asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock; same clock as the I2S receiver.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable; gates pushes only.
- flush  in  1  synchronous FIFO clear.
- chan_mode  in  2  0 = keep left (ws=0), 1 = keep right (ws=1), 2 or 3 = keep both.
- sample_in  in  32  I2S shift-register word.
- sample_valid  in  1  one-cycle done pulse from the I2S receiver.
- ws_in  in  1  I2S WS level, sampled with sample_valid.
- dma_req  out  1  FIFO level >= THRESHOLD.
- dma_ack  in  1  pop one entry this cycle.
- rd_data  out  32  head entry (FIFO output).
- rd_chan  out  1  channel tag of the head entry.
- level  out  $clog2(DEPTH)+1  current fill count.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.
- clr_flags  in  1  clears ovf and udf.

Behaviour:
- Reset (rst=1 at a clk edge):
  - read pointer, write pointer and level = 0.
  - ovf = 0, udf = 0, dma_req = 0, empty = 1, full = 0.
  - rd_data and rd_chan = 0.
  - Reset mid-burst discards all contents; a sample_valid in the same cycle is dropped.
- Format:
  - entry = sample_in[31 -: SAMPLE_BITS], sign-extended to 32 bits using sample_in[31].
  - Example, SAMPLE_BITS=18: 32'h8000_4000 -> 32'hFFFE_0001.
  - Tag = ws_in.
- Push request: sample_valid && en && (chan_mode[1] || ws_in == chan_mode[0]).
  - A rejected channel is silently dropped: no flag, no state change.
- Pop request: dma_ack.
- Per cycle, in priority order:
  1. rst: reset as above.
  2. flush: pointers and level = 0; flags are unchanged; a same-cycle push or pop is discarded.
  3. Otherwise:
     - Push when not full, or when full with a simultaneous pop.
     - Push into a full FIFO with no pop: sample dropped, ovf <= 1.
     - Pop when not empty.
     - Pop on an empty FIFO: ignored, udf <= 1. A same-cycle push is still accepted.
     - level += push_accepted - pop_accepted; pointers wrap modulo DEPTH.
- Flags:
  - ovf and udf are sticky until clr_flags.
  - If clr_flags coincides with a new overflow or underflow event, the set wins.
- Latency:
  - Sample pushed at edge N is visible on rd_data/rd_chan after edge N if the FIFO was empty (first-word fall-through).
  - level, empty, full and dma_req update after edge N.
  - rd_data is driven from storage at the read pointer: no output register, zero-cycle read.
  - After a pop at edge N, the next entry appears after edge N.
- dma_req:
  - Combinational from the level register: level >= THRESHOLD.
  - Deasserts the cycle after the pop that takes level below THRESHOLD.
  - The DMA controller must tolerate one extra request cycle.
- en:
  - en=0 blocks pushes only; the DMA may keep draining.
  - Toggling en never corrupts stored data.
- chan_mode may change at any time and applies from the next sample_valid.

Test Plan:
- Reset, then chan_mode=2, SAMPLE_BITS=18, push 32'h8000_4000 with ws=0 → after one edge: rd_data=32'hFFFE_0001, rd_chan=0, level=1, empty=0, dma_req=0.
- chan_mode=1, push 4 samples alternating ws=0/1 → level=2, only ws=1 entries stored, in arrival order.
- THRESHOLD=4, push 4 samples → dma_req=1 after the fourth push; one dma_ack → level=3, dma_req=0 on the next cycle.
- Fill to 8 (DEPTH=8), push a ninth sample → level=8, ovf=1, head unchanged. Push+ack in the same cycle while full → level stays 8, new sample stored at the tail. clr_flags → ovf=0.
- Empty FIFO, dma_ack together with sample_valid → udf=1, level=1, rd_data equals the pushed sample.
- Level=5, assert flush together with sample_valid → level=0, empty=1, dma_req=0, flags unchanged. Assert rst mid-stream → all outputs return to reset values.

Source files
------------

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo
// Takes the 32-bit word and done pulse from the I2S receiver and keeps the
// left, right or both channels. Each kept word is turned into a
// sign-extended sample tagged with its channel. Samples are buffered in a
// first-word-fall-through FIFO. A level-based request tells the DMA
// controller to drain the FIFO, one entry per acknowledge.
module i2s_sample_fifo #(
  parameter int DEPTH       = 8,
  parameter int SAMPLE_BITS = 18,
  parameter int THRESHOLD   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [1:0]                 chan_mode,
  input  logic [31:0]                sample_in,
  input  logic                       sample_valid,
  input  logic                       ws_in,
  output logic                       dma_req,
  input  logic                       dma_ack,
  output logic [31:0]                rd_data,
  output logic                       rd_chan,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       udf,
  input  logic                       clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_LVL = LW'(THRESHOLD);

  // Storage: sample data and channel tag, indexed by the ring pointers
  logic [31:0]   dataMem [DEPTH];
  logic          chanMem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [31:0]   entry;
  logic          chanKeep;
  logic          pushReq;
  logic          popReq;
  logic          isEmpty;
  logic          isFull;
  logic          pushAcc;
  logic          popAcc;
  logic          ovfSet;
  logic          udfSet;

  // Keep the top SAMPLE_BITS of the word. An arithmetic right shift
  // sign-extends them from bit 31 in one step.
  assign entry = 32'($signed(sample_in) >>> (32 - SAMPLE_BITS));

  // Decide whether this word's channel is wanted.
  // chan_mode[1] keeps both channels. Otherwise bit 0 selects the ws level to keep.
  assign chanKeep = chan_mode[1] || (ws_in == chan_mode[0]);
  assign pushReq  = sample_valid && en && chanKeep;
  assign popReq   = dma_ack;

  assign isEmpty  = (level_q == '0);
  assign isFull   = (level_q == DEPTH_LVL);

  // A full FIFO can still take a push if a pop frees a slot in the same cycle.
  // Full implies non-empty, so that pop is always accepted.
  assign popAcc   = popReq && !isEmpty;
  assign pushAcc  = pushReq && (!isFull || popReq);
  assign ovfSet   = pushReq && isFull && !popReq;
  assign udfSet   = popReq && isEmpty;

  // Next-state pointers, level and sticky flags.
  // Flush clears the ring and leaves the flags alone.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (pushAcc) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popAcc) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({pushAcc, popAcc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // A new event wins over a simultaneous clear.
      if (ovfSet) begin
        ovf_d = 1'b1;
      end else if (clr_flags) begin
        ovf_d = 1'b0;
      end
      if (udfSet) begin
        udf_d = 1'b1;
      end else if (clr_flags) begin
        udf_d = 1'b0;
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Write the formatted sample into the tail slot.
  // Reset and flush discard any push made in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && !flush && pushAcc) begin
      dataMem[wrPtr_q] <= entry;
      chanMem[wrPtr_q] <= ws_in;
    end
  end

  // Show the head entry straight from storage (fall-through).
  // The output is forced to zero while empty, so reset leaves it at zero.
  always_comb begin
    rd_data = '0;
    rd_chan = 1'b0;
    if (!isEmpty) begin
      rd_data = dataMem[rdPtr_q];
      rd_chan = chanMem[rdPtr_q];
    end
  end

  assign level   = level_q;
  assign empty   = isEmpty;
  assign full    = isFull;
  assign dma_req = (level_q >= THRESH_LVL);
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule
